// File: rtl/datamem_arbiter_if.sv
// Requester and memory-side bus of the data-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding datapath/memory.
interface datamem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_err;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_datawrite;
    logic              mem_memwrite;
    logic              mem_memread;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata, dma_err,
        output mem_address, mem_datawrite, mem_memwrite, mem_memread,
        input  mem_readdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata, dma_err,
        input  mem_address, mem_datawrite, mem_memwrite, mem_memread,
        output mem_readdata
    );
endinterface

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between CPU and DMA.
// Optional DMA write protection below PROT_TOP is enabled by DATAMEM_ARB_PROT_EN.
module datamem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 1,
    parameter int PROT_TOP = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    datamem_arbiter_if.slave     bus,
    output logic                 busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam int   CNT_W   = 2;
    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DMA = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pick_dma;
    logic              sel_we;
    logic              capture;

    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic              dma_err_q, dma_err_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_datawrite_q, mem_datawrite_d;
    logic              mem_memwrite_q, mem_memwrite_d;
    logic              mem_memread_q, mem_memread_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q [2];

`ifdef DATAMEM_ARB_PROT_EN
    logic              prot_q, prot_d;
`endif

    // DMA wins only when CPU is idle or the CPU was served last.
    assign pick_dma = bus.dma_req && (!bus.cpu_req || (last_grant_q == GNT_CPU));
    assign sel_we   = pick_dma ? bus.dma_we : bus.cpu_we;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        capture      = 1'b0;
`ifdef DATAMEM_ARB_PROT_EN
        prot_d       = prot_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    gnt_d        = pick_dma;
                    last_grant_d = pick_dma;
                    addr_d       = pick_dma ? bus.dma_addr  : bus.cpu_addr;
                    wdata_d      = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
                    we_d         = sel_we;
                    cnt_d        = '0;
                    state_d      = sel_we ? S_WRITE : S_READ;
`ifdef DATAMEM_ARB_PROT_EN
                    prot_d       = 1'b0;
                    if (pick_dma && bus.dma_we && (bus.dma_addr < ADDR_W'(PROT_TOP))) begin
                        prot_d  = 1'b1;
                        state_d = S_ACK;
                    end
`endif
                end
            end
            S_WRITE: state_d = S_ACK;
            S_READ: begin
                if (cnt_q == CNT_LAST) begin
                    capture = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        mem_memwrite_d  = (state_d == S_WRITE);
        mem_memread_d   = (state_d == S_READ);
        mem_address_d   = (mem_memwrite_d || mem_memread_d) ? addr_d : '0;
        mem_datawrite_d = mem_memwrite_d ? wdata_d : '0;
        cpu_ack_d       = (state_d == S_ACK) && (gnt_d == GNT_CPU);
        dma_ack_d       = (state_d == S_ACK) && (gnt_d == GNT_DMA);
        busy_d          = (state_d != S_IDLE);
`ifdef DATAMEM_ARB_PROT_EN
        dma_err_d       = dma_ack_d && prot_d;
`else
        dma_err_d       = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            last_grant_q    <= GNT_DMA;
            gnt_q           <= GNT_CPU;
            addr_q          <= '0;
            wdata_q         <= '0;
            we_q            <= 1'b0;
            cnt_q           <= '0;
            cpu_ack_q       <= 1'b0;
            dma_ack_q       <= 1'b0;
            dma_err_q       <= 1'b0;
            mem_address_q   <= '0;
            mem_datawrite_q <= '0;
            mem_memwrite_q  <= 1'b0;
            mem_memread_q   <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            gnt_q           <= gnt_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            we_q            <= we_d;
            cnt_q           <= cnt_d;
            cpu_ack_q       <= cpu_ack_d;
            dma_ack_q       <= dma_ack_d;
            dma_err_q       <= dma_err_d;
            mem_address_q   <= mem_address_d;
            mem_datawrite_q <= mem_datawrite_d;
            mem_memwrite_q  <= mem_memwrite_d;
            mem_memread_q   <= mem_memread_d;
            busy_q          <= busy_d;
        end
    end

`ifdef DATAMEM_ARB_PROT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            prot_q <= 1'b0;
        end else begin
            prot_q <= prot_d;
        end
    end
`endif

    // Per-requester read-data holders; only the granted one is ever loaded.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q[gi] <= '0;
                end else if (capture && (gnt_q == 1'(gi))) begin
                    rdata_q[gi] <= bus.mem_readdata;
                end
            end
        end
    endgenerate

    assign bus.cpu_ack       = cpu_ack_q;
    assign bus.cpu_rdata     = rdata_q[0];
    assign bus.dma_ack       = dma_ack_q;
    assign bus.dma_rdata     = rdata_q[1];
    assign bus.dma_err       = dma_err_q;
    assign bus.mem_address   = mem_address_q;
    assign bus.mem_datawrite = mem_datawrite_q;
    assign bus.mem_memwrite  = mem_memwrite_q;
    assign bus.mem_memread   = mem_memread_q;
    assign busy              = busy_q;
endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed self-checking bench for datamem_arbiter with RD_LAT = 2 and a small memory model.
module tb_datamem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    datamem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    datamem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(2), .PROT_TOP(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    // Memory model: unwritten words read back as {addr[7:0], 8'h5A}.
    logic [15:0]  mem [256];
    logic [255:0] written;
    logic [7:0]   ma;
    assign ma = bus.mem_address[7:0];
    assign bus.mem_readdata = bus.mem_memread ? (written[ma] ? mem[ma] : {ma, 8'h5A}) : 16'h0000;

    always @(posedge clk) begin
        if (rst) begin
            written <= '0;
        end else if (bus.mem_memwrite) begin
            mem[ma]     <= bus.mem_datawrite;
            written[ma] <= 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL rst_cpu_ack got=%h exp=0", bus.cpu_ack); end
        checks++; if (bus.dma_ack !== 1'b0) begin failures++; $display("FAIL rst_dma_ack got=%h exp=0", bus.dma_ack); end
        checks++; if (bus.dma_err !== 1'b0) begin failures++; $display("FAIL rst_dma_err got=%h exp=0", bus.dma_err); end
        checks++; if (bus.mem_memwrite !== 1'b0) begin failures++; $display("FAIL rst_memwrite got=%h exp=0", bus.mem_memwrite); end
        checks++; if (bus.mem_memread !== 1'b0) begin failures++; $display("FAIL rst_memread got=%h exp=0", bus.mem_memread); end
        checks++; if (bus.mem_address !== 16'h0) begin failures++; $display("FAIL rst_address got=%h exp=0000", bus.mem_address); end
        checks++; if (bus.cpu_rdata !== 16'h0) begin failures++; $display("FAIL rst_cpu_rdata got=%h exp=0000", bus.cpu_rdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%h exp=0", busy); end
        rst = 1'b0;
        step();
        $display("TXN reset done");
    endtask

    task automatic test_cpu_write();
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0005; bus.cpu_wdata = 16'h1234;
        step();
        checks++; if (bus.mem_memwrite !== 1'b1) begin failures++; $display("FAIL wr_memwrite got=%h exp=1", bus.mem_memwrite); end
        checks++; if (bus.mem_address !== 16'h0005) begin failures++; $display("FAIL wr_address got=%h exp=0005", bus.mem_address); end
        checks++; if (bus.mem_datawrite !== 16'h1234) begin failures++; $display("FAIL wr_datawrite got=%h exp=1234", bus.mem_datawrite); end
        checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL wr_early_ack got=%h exp=0", bus.cpu_ack); end
        step();
        checks++; if (bus.mem_memwrite !== 1'b0) begin failures++; $display("FAIL wr_memwrite_1cyc got=%h exp=0", bus.mem_memwrite); end
        checks++; if (bus.cpu_ack !== 1'b1) begin failures++; $display("FAIL wr_cpu_ack got=%h exp=1", bus.cpu_ack); end
        checks++; if (bus.dma_ack !== 1'b0) begin failures++; $display("FAIL wr_dma_ack got=%h exp=0", bus.dma_ack); end
        bus.cpu_req = 0;
        step();
        checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_pulse got=%h exp=0", bus.cpu_ack); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_idle got=%h exp=0", busy); end
        checks++; if (mem[5] !== 16'h1234) begin failures++; $display("FAIL wr_mem_content got=%h exp=1234", mem[5]); end
        $display("TXN cpu store addr=0005 data=1234");
    endtask

    task automatic test_cpu_read();
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0005;
        step();
        checks++; if (bus.mem_memread !== 1'b1) begin failures++; $display("FAIL rd_memread_c1 got=%h exp=1", bus.mem_memread); end
        checks++; if (bus.mem_address !== 16'h0005) begin failures++; $display("FAIL rd_address got=%h exp=0005", bus.mem_address); end
        checks++; if (bus.mem_memwrite !== 1'b0) begin failures++; $display("FAIL rd_memwrite got=%h exp=0", bus.mem_memwrite); end
        step();
        checks++; if (bus.mem_memread !== 1'b1) begin failures++; $display("FAIL rd_memread_c2 got=%h exp=1", bus.mem_memread); end
        checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL rd_early_ack got=%h exp=0", bus.cpu_ack); end
        step();
        checks++; if (bus.cpu_ack !== 1'b1) begin failures++; $display("FAIL rd_cpu_ack got=%h exp=1", bus.cpu_ack); end
        checks++; if (bus.mem_memread !== 1'b0) begin failures++; $display("FAIL rd_memread_c3 got=%h exp=0", bus.mem_memread); end
        checks++; if (bus.cpu_rdata !== 16'h1234) begin failures++; $display("FAIL rd_rdata got=%h exp=1234", bus.cpu_rdata); end
        bus.cpu_req = 0;
        repeat (2) step();
        checks++; if (bus.cpu_rdata !== 16'h1234) begin failures++; $display("FAIL rd_rdata_hold got=%h exp=1234", bus.cpu_rdata); end
        $display("TXN cpu load addr=0005 rdata=%h", bus.cpu_rdata);
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_addr;
        logic        dma_turn;
        int          phase;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0010;
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 16'h0020;
        for (int i = 0; i < 16; i++) begin
            step();
            phase    = i % 4;
            dma_turn = ((i / 4) % 2) == 1;
            exp_addr = dma_turn ? 16'h0020 : 16'h0010;
            if (i == 15) begin
                bus.cpu_req = 0;
                bus.dma_req = 0;
            end
            checks++; if (bus.cpu_ack !== (phase == 2 && !dma_turn)) begin failures++; $display("FAIL rr_cpu_ack cyc=%0d got=%h exp=%h", i, bus.cpu_ack, (phase == 2 && !dma_turn)); end
            checks++; if (bus.dma_ack !== (phase == 2 && dma_turn)) begin failures++; $display("FAIL rr_dma_ack cyc=%0d got=%h exp=%h", i, bus.dma_ack, (phase == 2 && dma_turn)); end
            checks++; if (busy !== (phase != 3)) begin failures++; $display("FAIL rr_busy cyc=%0d got=%h exp=%h", i, busy, (phase != 3)); end
            checks++; if (bus.mem_memread !== (phase < 2)) begin failures++; $display("FAIL rr_memread cyc=%0d got=%h exp=%h", i, bus.mem_memread, (phase < 2)); end
            checks++; if (bus.mem_memwrite !== 1'b0) begin failures++; $display("FAIL rr_memwrite cyc=%0d got=%h exp=0", i, bus.mem_memwrite); end
            if (phase < 2) begin
                checks++; if (bus.mem_address !== exp_addr) begin failures++; $display("FAIL rr_address cyc=%0d got=%h exp=%h", i, bus.mem_address, exp_addr); end
            end
            if (i == 2) begin
                checks++; if (bus.dma_rdata !== 16'h0000) begin failures++; $display("FAIL rr_dma_rdata_untouched got=%h exp=0000", bus.dma_rdata); end
            end
            if (phase == 2) $display("TXN rr ack %s cyc=%0d", dma_turn ? "dma" : "cpu", i);
        end
        checks++; if (bus.cpu_rdata !== 16'h105A) begin failures++; $display("FAIL rr_cpu_rdata got=%h exp=105a", bus.cpu_rdata); end
        checks++; if (bus.dma_rdata !== 16'h205A) begin failures++; $display("FAIL rr_dma_rdata got=%h exp=205a", bus.dma_rdata); end
        step();
    endtask

    task automatic test_reset_mid_write();
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 16'h0030; bus.dma_wdata = 16'h5555;
        step();
        checks++; if (bus.mem_memwrite !== 1'b1) begin failures++; $display("FAIL rmw_in_write got=%h exp=1", bus.mem_memwrite); end
        rst = 1'b1;
        step();
        checks++; if (bus.mem_memwrite !== 1'b0) begin failures++; $display("FAIL rmw_memwrite got=%h exp=0", bus.mem_memwrite); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmw_busy got=%h exp=0", busy); end
        checks++; if (bus.dma_ack !== 1'b0) begin failures++; $display("FAIL rmw_dma_ack got=%h exp=0", bus.dma_ack); end
        rst = 1'b0;
        bus.dma_req = 0;
        step();
        checks++; if (bus.dma_ack !== 1'b0) begin failures++; $display("FAIL rmw_dma_ack_late got=%h exp=0", bus.dma_ack); end
        $display("TXN dma write addr=0030 abandoned by reset");
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0031; bus.cpu_wdata = 16'h7777;
        step();
        checks++; if (bus.mem_address !== 16'h0031) begin failures++; $display("FAIL rmw_next_address got=%h exp=0031", bus.mem_address); end
        step();
        checks++; if (bus.cpu_ack !== 1'b1) begin failures++; $display("FAIL rmw_next_ack got=%h exp=1", bus.cpu_ack); end
        bus.cpu_req = 0;
        step();
        checks++; if (mem[8'h31] !== 16'h7777) begin failures++; $display("FAIL rmw_next_mem got=%h exp=7777", mem[8'h31]); end
        $display("TXN cpu store addr=0031 data=7777 after reset");
    endtask

    task automatic test_latch();
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 16'h0040; bus.dma_wdata = 16'h1111;
        step();
        bus.dma_addr = 16'h0041; bus.dma_wdata = 16'h2222;
        checks++; if (bus.mem_address !== 16'h0040) begin failures++; $display("FAIL latch_address got=%h exp=0040", bus.mem_address); end
        checks++; if (bus.mem_datawrite !== 16'h1111) begin failures++; $display("FAIL latch_wdata got=%h exp=1111", bus.mem_datawrite); end
        step();
        checks++; if (bus.dma_ack !== 1'b1) begin failures++; $display("FAIL latch_dma_ack got=%h exp=1", bus.dma_ack); end
        checks++; if (bus.dma_err !== 1'b0) begin failures++; $display("FAIL latch_dma_err got=%h exp=0", bus.dma_err); end
        bus.dma_req = 0;
        step();
        checks++; if (mem[8'h40] !== 16'h1111) begin failures++; $display("FAIL latch_mem got=%h exp=1111", mem[8'h40]); end
        checks++; if (written[8'h41] !== 1'b0) begin failures++; $display("FAIL latch_stray_write got=%h exp=0", written[8'h41]); end
        $display("TXN dma write addr=0040 data=1111 latched");
    endtask

    task automatic test_protection();
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 16'h0003; bus.dma_wdata = 16'hDEAD;
        step();
`ifdef DATAMEM_ARB_PROT_EN
        checks++; if (bus.mem_memwrite !== 1'b0) begin failures++; $display("FAIL prot_memwrite got=%h exp=0", bus.mem_memwrite); end
        checks++; if (bus.dma_ack !== 1'b1) begin failures++; $display("FAIL prot_dma_ack got=%h exp=1", bus.dma_ack); end
        checks++; if (bus.dma_err !== 1'b1) begin failures++; $display("FAIL prot_dma_err got=%h exp=1", bus.dma_err); end
        bus.dma_req = 0;
        step();
        checks++; if (written[3] !== 1'b0) begin failures++; $display("FAIL prot_mem_untouched got=%h exp=0", written[3]); end
`else
        checks++; if (bus.mem_memwrite !== 1'b1) begin failures++; $display("FAIL prot_memwrite got=%h exp=1", bus.mem_memwrite); end
        step();
        checks++; if (bus.dma_ack !== 1'b1) begin failures++; $display("FAIL prot_dma_ack got=%h exp=1", bus.dma_ack); end
        checks++; if (bus.dma_err !== 1'b0) begin failures++; $display("FAIL prot_dma_err got=%h exp=0", bus.dma_err); end
        bus.dma_req = 0;
        step();
        checks++; if (mem[3] !== 16'hDEAD) begin failures++; $display("FAIL prot_mem_written got=%h exp=dead", mem[3]); end
`endif
        $display("TXN dma write addr=0003 err=%h", bus.dma_err);
        step();
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 16'h0008; bus.dma_wdata = 16'hBEEF;
        step();
        checks++; if (bus.mem_memwrite !== 1'b1) begin failures++; $display("FAIL prot8_memwrite got=%h exp=1", bus.mem_memwrite); end
        step();
        checks++; if (bus.dma_ack !== 1'b1) begin failures++; $display("FAIL prot8_dma_ack got=%h exp=1", bus.dma_ack); end
        checks++; if (bus.dma_err !== 1'b0) begin failures++; $display("FAIL prot8_dma_err got=%h exp=0", bus.dma_err); end
        bus.dma_req = 0;
        step();
        checks++; if (mem[8] !== 16'hBEEF) begin failures++; $display("FAIL prot8_mem got=%h exp=beef", mem[8]); end
        $display("TXN dma write addr=0008 data=beef");
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_round_robin();
        test_reset_mid_write();
        test_latch();
        test_protection();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
